input_word_loader: RTL and testbench

Parametrised successor to the board switch-input register: assembles a WIDTH-bit word from SLICE-bit switch slices selected by a rotating slice pointer, with synchronised, edge-detected key strobes and a valid/ready handoff to the consumer (CPU `in` / instruction load path). It sits between the DE1-SoC switches/keys and the datapath, replacing the fixed two-half 16-bit loader.

---
 rtl/input_word_loader.sv | 139 +++++++++++++
 tb/tb_input_word_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_word_loader.sv
// Switch-slice word loader: builds a WIDTH-bit word from SLICE-bit switch entries
// using synchronised key strobes, then publishes it over a valid/ready handoff.
module input_word_loader #(
    parameter  int WIDTH  = 16,
    parameter  int SLICE  = 8,
    localparam int NSLICE = WIDTH / SLICE,
    localparam int SEL_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SLICE-1:0] sw,
    input  logic             wr_key,
    input  logic             nxt_key,
    input  logic             commit_key,
    output logic [SEL_W-1:0] sel,
    output logic [SLICE-1:0] led,
    output logic [WIDTH-1:0] stage,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    // Key vectors are packed as {commit, nxt, wr}.
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_prev;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_stage;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overrun;

    logic [2:0]       w_keys;
    logic [2:0]       w_strobe;
    logic             w_accept;
    logic             w_drop;
    logic [WIDTH-1:0] w_stage_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_valid_nxt;
    logic [SLICE-1:0] w_led;

    function automatic logic [SEL_W-1:0] f_sel_wrap(input logic [SEL_W-1:0] cur);
        if (cur == SEL_W'(NSLICE - 1)) begin
            return {SEL_W{1'b0}};
        end else begin
            return cur + SEL_W'(1);
        end
    endfunction

    assign w_keys   = {commit_key, nxt_key, wr_key};
    assign w_strobe = r_sync2 & ~r_prev;
    // A commit is dropped only when the pending word is not being taken this cycle.
    assign w_accept = w_strobe[2] & (~r_out_valid | out_ready);
    assign w_drop   = w_strobe[2] & r_out_valid & ~out_ready;

    // Two-flop synchroniser plus previous-sample register for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_prev  <= 3'b000;
        end else begin
            r_sync1 <= w_keys;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Write strobe replaces only the slice addressed by the current pointer.
    always_comb begin
        w_stage_nxt = r_stage;
        for (int i = 0; i < NSLICE; i++) begin
            w_stage_nxt[i*SLICE +: SLICE] = (w_strobe[0] && (r_sel == SEL_W'(i)))
                                            ? sw : r_stage[i*SLICE +: SLICE];
        end
    end

    // Pointer and valid next-state; an accepted commit overrides a same-cycle advance.
    always_comb begin
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_out_valid;
        if (w_accept) begin
            w_sel_nxt = {SEL_W{1'b0}};
        end else if (w_strobe[1]) begin
            w_sel_nxt = f_sel_wrap(r_sel);
        end else begin
            w_sel_nxt = r_sel;
        end
        if (w_accept) begin
            w_valid_nxt = 1'b1;
        end else if (r_out_valid && out_ready) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_out_valid;
        end
    end

    // Slice display decoded from registered state only.
    always_comb begin
        w_led = {SLICE{1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            w_led = w_led | (r_stage[i*SLICE +: SLICE] & {SLICE{r_sel == SEL_W'(i)}});
        end
    end

    // Datapath state: staged word, pointer, published word and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel       <= {SEL_W{1'b0}};
            r_stage     <= {WIDTH{1'b0}};
            r_out_data  <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sel       <= w_sel_nxt;
            r_stage     <= w_stage_nxt;
            r_out_valid <= w_valid_nxt;
            if (w_accept) begin
                r_out_data <= w_stage_nxt;
            end else begin
                r_out_data <= r_out_data;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign sel       = r_sel;
    assign led       = w_led;
    assign stage     = r_stage;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_input_word_loader.sv
// Scoreboard bench for input_word_loader: default 16/8 instance and a 32/4 instance.
module tb_input_word_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0]  sw16;
    logic [2:0]  keys16;
    logic        ready16;
    logic [0:0]  sel16;
    logic [7:0]  led16;
    logic [15:0] stage16, data16;
    logic        valid16, ovr16;

    logic [3:0]  sw32;
    logic [2:0]  keys32;
    logic        ready32;
    logic [2:0]  sel32;
    logic [3:0]  led32;
    logic [31:0] stage32, data32;
    logic        valid32, ovr32;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] q16[$];
    logic [31:0] q32[$];
    logic [15:0] e16;
    logic [31:0] e32;

    input_word_loader dut16 (
        .clk(clk), .reset(reset), .sw(sw16),
        .wr_key(keys16[0]), .nxt_key(keys16[1]), .commit_key(keys16[2]),
        .sel(sel16), .led(led16), .stage(stage16), .out_data(data16),
        .out_valid(valid16), .out_ready(ready16), .overrun(ovr16)
    );

    input_word_loader #(.WIDTH(32), .SLICE(4)) dut32 (
        .clk(clk), .reset(reset), .sw(sw32),
        .wr_key(keys32[0]), .nxt_key(keys32[1]), .commit_key(keys32[2]),
        .sel(sel32), .led(led32), .stage(stage32), .out_data(data32),
        .out_valid(valid32), .out_ready(ready32), .overrun(ovr32)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic press16(input logic [2:0] k);
        @(posedge clk); #1 keys16 = k;
        @(posedge clk);
        @(posedge clk); #1 keys16 = 3'b000;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press32(input logic [2:0] k);
        @(posedge clk); #1 keys32 = k;
        @(posedge clk);
        @(posedge clk); #1 keys32 = 3'b000;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && valid16 && ready16) begin
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut16_unexpected_word: got %h, expected none", data16);
            end else begin
                e16 = q16.pop_front();
                chk("dut16_published_word", {16'h0000, data16}, {16'h0000, e16});
            end
        end
        if (!reset && valid32 && ready32) begin
            if (q32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut32_unexpected_word: got %h, expected none", data32);
            end else begin
                e32 = q32.pop_front();
                chk("dut32_published_word", data32, e32);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        sw16 = 8'h00; keys16 = 3'b000; ready16 = 1'b0;
        sw32 = 4'h0;  keys32 = 3'b000; ready32 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_stage", {16'h0000, stage16}, 32'h0);
        chk("rst_sel", {31'h0, sel16}, 32'h0);
        chk("rst_valid", {31'h0, valid16}, 32'h0);
        chk("rst_overrun", {31'h0, ovr16}, 32'h0);

        // Basic assembly 0x1234
        sw16 = 8'h34; press16(3'b001);
        chk("wr_lo_stage", {16'h0000, stage16}, 32'h0034);
        chk("wr_lo_led", {24'h0, led16}, 32'h34);
        press16(3'b010);
        chk("nxt_sel", {31'h0, sel16}, 32'h1);
        chk("nxt_led", {24'h0, led16}, 32'h00);
        sw16 = 8'h12; press16(3'b001);
        chk("wr_hi_stage", {16'h0000, stage16}, 32'h1234);
        q16.push_back(16'h1234);
        press16(3'b100);
        chk("commit_data", {16'h0000, data16}, 32'h1234);
        chk("commit_valid", {31'h0, valid16}, 32'h1);
        chk("commit_sel", {31'h0, sel16}, 32'h0);
        chk("commit_led", {24'h0, led16}, 32'h34);
        chk("commit_stage_kept", {16'h0000, stage16}, 32'h1234);

        // Overrun: commit while the word is still pending is dropped
        sw16 = 8'h99; press16(3'b001);
        press16(3'b010);
        press16(3'b100);
        chk("ovr_data_held", {16'h0000, data16}, 32'h1234);
        chk("ovr_flag", {31'h0, ovr16}, 32'h1);
        chk("ovr_sel_held", {31'h0, sel16}, 32'h1);
        chk("ovr_valid_held", {31'h0, valid16}, 32'h1);

        // Accept: out_valid falls one edge after ready rises
        @(posedge clk); #1 ready16 = 1'b1;
        @(posedge clk); #1;
        chk("accept_valid_low", {31'h0, valid16}, 32'h0);
        chk("accept_data_hold", {16'h0000, data16}, 32'h1234);

        // Same-cycle write + commit at sel=1
        sw16 = 8'hEE;
        q16.push_back(16'hEE99);
        press16(3'b101);
        chk("wrc_data", {16'h0000, data16}, 32'hEE99);
        chk("wrc_sel", {31'h0, sel16}, 32'h0);
        chk("wrc_valid", {31'h0, valid16}, 32'h0);
        chk("wrc_overrun_sticky", {31'h0, ovr16}, 32'h1);

        // Back-to-back commits with ready held high
        sw16 = 8'h77; press16(3'b001);
        q16.push_back(16'hEE77); press16(3'b100);
        q16.push_back(16'hEE77); press16(3'b100);
        chk("b2b_data", {16'h0000, data16}, 32'hEE77);

        // Long wr hold: one write with the strobe-cycle sw value
        @(posedge clk); #1 sw16 = 8'h56; keys16 = 3'b001;
        @(posedge clk);
        @(posedge clk); #1;
        chk("hold_before_effect", {24'h0, stage16[7:0]}, 32'h77);
        @(posedge clk); #1;
        chk("hold_effect", {24'h0, stage16[7:0]}, 32'h56);
        for (int i = 0; i < 18; i++) begin
            sw16 = 8'hA0 + 8'(i);
            @(posedge clk); #1;
        end
        keys16 = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_single_write", {16'h0000, stage16}, 32'hEE56);
        chk("hold_sel", {31'h0, sel16}, 32'h0);

        // Reset mid-handshake with stage 0x00AB pending
        ready16 = 1'b0;
        press16(3'b010);
        sw16 = 8'h00; press16(3'b001);
        press16(3'b010);
        chk("wrap_sel", {31'h0, sel16}, 32'h0);
        sw16 = 8'hAB; press16(3'b001);
        chk("pre_rst_stage", {16'h0000, stage16}, 32'h00AB);
        q16.push_back(16'h00AB);
        press16(3'b100);
        chk("pre_rst_valid", {31'h0, valid16}, 32'h1);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("async_rst_stage", {16'h0000, stage16}, 32'h0);
        chk("async_rst_sel", {31'h0, sel16}, 32'h0);
        chk("async_rst_led", {24'h0, led16}, 32'h0);
        chk("async_rst_data", {16'h0000, data16}, 32'h0);
        chk("async_rst_valid", {31'h0, valid16}, 32'h0);
        chk("async_rst_overrun", {31'h0, ovr16}, 32'h0);
        q16.delete();
        @(posedge clk); #1 reset = 1'b0;

        // 32/4 instance: pointer wrap over eight slices
        for (int i = 0; i < 8; i++) begin
            press32(3'b010);
            chk("w32_sel_step", {29'h0, sel32}, 32'((i + 1) % 8));
        end
        for (int i = 0; i < 8; i++) begin
            sw32 = 4'(i + 1);
            press32(3'b001);
            chk("w32_led", {28'h0, led32}, 32'(i + 1));
            press32(3'b010);
        end
        chk("w32_stage", stage32, 32'h87654321);
        chk("w32_sel_wrapped", {29'h0, sel32}, 32'h0);
        ready32 = 1'b1;
        q32.push_back(32'h87654321);
        press32(3'b100);
        chk("w32_data", data32, 32'h87654321);
        chk("w32_valid_low", {31'h0, valid32}, 32'h0);

        chk("q16_drained", 32'(q16.size()), 32'h0);
        chk("q32_drained", 32'(q32.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
